// File: rtl/logicnet_input_packer_if.sv
// Feature-in / frame-out handshake bundle for logicnet_input_packer.
// "slave" is the packer's view; "master" is the upstream source / downstream sink view.
interface logicnet_input_packer_if #(
    parameter int N_FEAT = 16,
    parameter int IN_W   = 16,
    parameter int Q_BITS = 2
);
    logic                     s_valid;
    logic                     s_ready;
    logic [IN_W-1:0]          s_data;
    logic                     s_last;
    logic                     m_valid;
    logic                     m_ready;
    logic [N_FEAT*Q_BITS-1:0] m_data;
    logic                     frame_err;

    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_data, frame_err
    );

    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_data, frame_err
    );
endinterface

// File: rtl/logicnet_input_packer.sv
// Quantizes raw features to Q_BITS codes and packs N_FEAT of them into a double-buffered frame.
// Define QPACK_LAST_CHECK_EN to check s_last framing and report violations on frame_err.
module logicnet_input_packer #(
    parameter int N_FEAT = 16,
    parameter int IN_W   = 16,
    parameter int Q_BITS = 2,
    parameter int SHIFT  = 12
) (
    input  logic                    clk,
    input  logic                    rst,
    logicnet_input_packer_if.slave  bus
);
    localparam int FRAME_W = N_FEAT * Q_BITS;
    localparam int IDX_W   = (N_FEAT > 1) ? $clog2(N_FEAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_FEAT - 1);
    localparam logic [IN_W-1:0]  CODE_MAX = IN_W'((2 ** Q_BITS) - 1);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } asm_state_t;

    // Logical right shift, then clamp to the largest code.
    function automatic logic [Q_BITS-1:0] quantize(input logic [IN_W-1:0] raw);
        logic [IN_W-1:0] t;
        t = raw >> SHIFT;
        if (t > CODE_MAX) begin
            quantize = CODE_MAX[Q_BITS-1:0];
        end else begin
            quantize = t[Q_BITS-1:0];
        end
    endfunction

    asm_state_t         asm_state_r;
    asm_state_t         asm_state_s;
    logic [IDX_W-1:0]   idx_r;
    logic [IDX_W-1:0]   idx_s;
    logic [FRAME_W-1:0] asm_buf_r;
    logic [FRAME_W-1:0] asm_buf_s;
    logic [FRAME_W-1:0] frame_s;
    logic               m_valid_r;
    logic               m_valid_s;
    logic [FRAME_W-1:0] m_data_r;
    logic [FRAME_W-1:0] m_data_s;
    logic [Q_BITS-1:0]  code_s;
    logic               accept_s;
    logic               last_slot_s;
    logic               bad_frame_s;
    logic               complete_s;
    logic               out_free_s;
    logic               transfer_s;

    assign accept_s    = bus.s_valid && (asm_state_r == ST_FILL);
    assign last_slot_s = (idx_r == IDX_LAST);
    assign code_s      = quantize(bus.s_data);

`ifdef QPACK_LAST_CHECK_EN
    logic frame_err_r;

    assign bad_frame_s = accept_s && (bus.s_last != last_slot_s);

    // One-cycle pulse for each misframed beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err_r <= 1'b0;
        end else begin
            frame_err_r <= bad_frame_s;
        end
    end

    assign bus.frame_err = frame_err_r;
`else
    assign bad_frame_s   = 1'b0;
    assign bus.frame_err = 1'b0;
`endif

    // The completing beat counts as a full buffer, so a frame leaves one clock after its last beat.
    assign complete_s = accept_s && last_slot_s && !bad_frame_s;
    assign out_free_s = !m_valid_r || bus.m_ready;
    assign transfer_s = ((asm_state_r == ST_FULL) || complete_s) && out_free_s;

    // Assembly buffer with the current beat's code merged into its slot.
    always_comb begin
        frame_s = asm_buf_r;
        for (int i = 0; i < N_FEAT; i++) begin
            frame_s[i*Q_BITS +: Q_BITS] = (accept_s && (idx_r == IDX_W'(i)))
                                          ? code_s : asm_buf_r[i*Q_BITS +: Q_BITS];
        end
    end

    // Assembly FSM: slot index, buffer contents and fill/full state.
    always_comb begin
        asm_state_s = asm_state_r;
        idx_s       = idx_r;
        asm_buf_s   = asm_buf_r;
        case (asm_state_r)
            ST_FILL: begin
                if (bad_frame_s) begin
                    idx_s     = {IDX_W{1'b0}};
                    asm_buf_s = {FRAME_W{1'b0}};
                end else if (complete_s) begin
                    idx_s       = {IDX_W{1'b0}};
                    asm_buf_s   = transfer_s ? {FRAME_W{1'b0}} : frame_s;
                    asm_state_s = transfer_s ? ST_FILL : ST_FULL;
                end else if (accept_s) begin
                    idx_s     = idx_r + IDX_W'(1);
                    asm_buf_s = frame_s;
                end else begin
                    idx_s = idx_r;
                end
            end
            ST_FULL: begin
                if (transfer_s) begin
                    asm_state_s = ST_FILL;
                    asm_buf_s   = {FRAME_W{1'b0}};
                end else begin
                    asm_state_s = ST_FULL;
                end
            end
            default: begin
                asm_state_s = ST_FILL;
                idx_s       = {IDX_W{1'b0}};
                asm_buf_s   = {FRAME_W{1'b0}};
            end
        endcase
    end

    // Output buffer: a pending transfer replaces a consumed frame with no bubble.
    always_comb begin
        m_valid_s = m_valid_r;
        m_data_s  = m_data_r;
        if (transfer_s) begin
            m_valid_s = 1'b1;
            m_data_s  = frame_s;
        end else if (bus.m_ready) begin
            m_valid_s = 1'b0;
        end else begin
            m_valid_s = m_valid_r;
        end
    end

    // State registers; reset drops any partial or held frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            asm_state_r <= ST_FILL;
            idx_r       <= {IDX_W{1'b0}};
            asm_buf_r   <= {FRAME_W{1'b0}};
            m_valid_r   <= 1'b0;
            m_data_r    <= {FRAME_W{1'b0}};
        end else begin
            asm_state_r <= asm_state_s;
            idx_r       <= idx_s;
            asm_buf_r   <= asm_buf_s;
            m_valid_r   <= m_valid_s;
            m_data_r    <= m_data_s;
        end
    end

    assign bus.s_ready = (asm_state_r == ST_FILL);
    assign bus.m_valid = m_valid_r;
    assign bus.m_data  = m_data_r;

endmodule

// File: tb/tb_logicnet_input_packer.sv
// Scoreboard bench: two packers (SHIFT=4 and SHIFT=0) with N_FEAT=4, IN_W=8, Q_BITS=2.
module tb_logicnet_input_packer;
    localparam int N  = 4;
    localparam int IW = 8;
    localparam int QB = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logicnet_input_packer_if #(.N_FEAT(N), .IN_W(IW), .Q_BITS(QB)) bus4();
    logicnet_input_packer_if #(.N_FEAT(N), .IN_W(IW), .Q_BITS(QB)) bus0();

    logicnet_input_packer #(.N_FEAT(N), .IN_W(IW), .Q_BITS(QB), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    logicnet_input_packer #(.N_FEAT(N), .IN_W(IW), .Q_BITS(QB), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [7:0] q4[$];
    logic [7:0] q0[$];
    bit gap_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the SHIFT=4 packer: frame order, hold stability and frame period.
    logic       held4 = 1'b0;
    logic [7:0] held_data4 = 8'h00;
    int         last_hs4 = 0;
    bit         last_gap4 = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            if (held4) begin
                check("hold_valid", bus4.m_valid, 1);
                check("hold_data", bus4.m_data, held_data4);
            end
            if (bus4.m_valid && bus4.m_ready) begin
                if (q4.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame4: got %0h, expected no frame", bus4.m_data);
                end else begin
                    check("frame4", bus4.m_data, q4.pop_front());
                end
                if (gap_en && last_gap4) check("frame_period", cyc - last_hs4, N);
                last_hs4  = cyc;
                last_gap4 = gap_en;
            end
            held4      = bus4.m_valid && !bus4.m_ready;
            held_data4 = bus4.m_data;
        end else begin
            held4 = 1'b0;
        end
    end

    // Monitor for the SHIFT=0 packer.
    always @(negedge clk) begin
        if (!rst && bus0.m_valid && bus0.m_ready) begin
            if (q0.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame0: got %0h, expected no frame", bus0.m_data);
            end else begin
                check("frame0", bus0.m_data, q0.pop_front());
            end
        end
    end

    task automatic send(input bit sel0, input logic [7:0] d, input bit last);
        int n = 0;
        if (sel0) begin
            bus0.s_valid = 1'b1; bus0.s_data = d; bus0.s_last = last;
        end else begin
            bus4.s_valid = 1'b1; bus4.s_data = d; bus4.s_last = last;
        end
        @(negedge clk);
        while (((sel0 ? bus0.s_ready : bus4.s_ready) !== 1'b1) && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got s_ready=0 for 50 cycles, expected 1");
        end
        @(posedge clk);
        #1;
        bus0.s_valid = 1'b0;
        bus4.s_valid = 1'b0;
    endtask

    // Four beats, first beat in the low byte, s_last on the fourth.
    task automatic sendf(input bit sel0, input logic [31:0] beats);
        for (int i = 0; i < N; i++) send(sel0, beats[i*8 +: 8], (i == N - 1));
    endtask

    initial begin
        bus4.s_valid = 1'b0; bus4.s_data = 8'h00; bus4.s_last = 1'b0; bus4.m_ready = 1'b1;
        bus0.s_valid = 1'b0; bus0.s_data = 8'h00; bus0.s_last = 1'b0; bus0.m_ready = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", bus4.m_valid, 0);
        check("rst_s_ready", bus4.s_ready, 1);
        check("rst_m_data", bus4.m_data, 0);
        check("rst_frame_err", bus4.frame_err, 0);
        check("rst_m_valid0", bus0.m_valid, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic packing and saturation, one-clock latency.
        q4.push_back(8'hE4);
        sendf(1'b0, 32'hFF2A1F05);
        check("t1_latency_valid", bus4.m_valid, 1);
        check("t1_latency_data", bus4.m_data, 8'hE4);
        @(posedge clk);
        #1;
        check("t1_valid_fall", bus4.m_valid, 0);

        // Back-pressure: held frame, second frame assembles, then back-to-back release.
        bus4.m_ready = 1'b0;
        q4.push_back(8'hFF);
        q4.push_back(8'h55);
        sendf(1'b0, 32'h30303030);
        check("t2_first_valid", bus4.m_valid, 1);
        check("t2_first_data", bus4.m_data, 8'hFF);
        sendf(1'b0, 32'h10101010);
        check("t2_s_ready_low", bus4.s_ready, 0);
        check("t2_held_data", bus4.m_data, 8'hFF);
        repeat (3) @(posedge clk);
        #1;
        check("t2_s_ready_still_low", bus4.s_ready, 0);
        bus4.m_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t2_no_bubble_valid", bus4.m_valid, 1);
        check("t2_no_bubble_data", bus4.m_data, 8'h55);
        check("t2_s_ready_back", bus4.s_ready, 1);
        @(posedge clk);
        #1;
        check("t2_valid_fall", bus4.m_valid, 0);

        // Continuous streaming: one frame every N cycles.
        gap_en = 1'b1;
        q4.push_back(8'hE4);
        q4.push_back(8'h1B);
        q4.push_back(8'hB7);
        sendf(1'b0, 32'h30201000);
        sendf(1'b0, 32'h00102030);
        sendf(1'b0, 32'h2F3F1540);
        repeat (3) @(posedge clk);
        #1;
        gap_en = 1'b0;

        // Reset mid-frame with a held frame: both are discarded.
        bus4.m_ready = 1'b0;
        sendf(1'b0, 32'h20202020);
        check("t4_held_before_rst", bus4.m_valid, 1);
        send(1'b0, 8'hFF, 1'b0);
        send(1'b0, 8'hFF, 1'b0);
        rst = 1'b1;
        #1;
        check("t4_rst_m_valid", bus4.m_valid, 0);
        check("t4_rst_s_ready", bus4.s_ready, 1);
        check("t4_rst_m_data", bus4.m_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus4.m_ready = 1'b1;
        q4.push_back(8'h81);
        sendf(1'b0, 32'h20000010);
        check("t4_fresh_valid", bus4.m_valid, 1);
        check("t4_fresh_data", bus4.m_data, 8'h81);
        @(posedge clk);
        #1;

        // SHIFT=0: direct codes, then saturation above 3.
        q0.push_back(8'h1E);
        sendf(1'b1, 32'h00010302);
        check("t5_valid", bus0.m_valid, 1);
        check("t5_data", bus0.m_data, 8'h1E);
        q0.push_back(8'h7F);
        sendf(1'b1, 32'h01FF0504);
        check("t5_sat_data", bus0.m_data, 8'h7F);
        @(posedge clk);
        #1;

`ifdef QPACK_LAST_CHECK_EN
        // Early s_last: error pulse, partial frame dropped, next frame normal.
        send(1'b0, 8'h10, 1'b0);
        send(1'b0, 8'h10, 1'b1);
        check("t6_err_pulse", bus4.frame_err, 1);
        check("t6_no_valid", bus4.m_valid, 0);
        @(posedge clk);
        #1;
        check("t6_err_clear", bus4.frame_err, 0);
        q4.push_back(8'h03);
        sendf(1'b0, 32'h00000030);
        check("t6_next_valid", bus4.m_valid, 1);
        check("t6_next_data", bus4.m_data, 8'h03);
`else
        // s_last is ignored: an early s_last still yields a full frame.
        q4.push_back(8'h55);
        send(1'b0, 8'h10, 1'b0);
        send(1'b0, 8'h10, 1'b1);
        check("t6_no_err", bus4.frame_err, 0);
        send(1'b0, 8'h10, 1'b0);
        send(1'b0, 8'h10, 1'b0);
        check("t6_ignored_valid", bus4.m_valid, 1);
        check("t6_ignored_data", bus4.m_data, 8'h55);
`endif

        repeat (5) @(posedge clk);
        #1;
        check("drain_q4", q4.size(), 0);
        check("drain_q0", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1);
    end
endmodule
